// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE status flags and the round-robin pointer helper
// used by the HUB opgroup output arbiter.
package fpnew_pkg;

  typedef struct packed {
    logic nv;  // invalid operation
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;

  // Modulo-num increment of a slice index; num-1 wraps to 0.
  function automatic int unsigned rr_next_idx(input int unsigned current,
                                              input int unsigned num);
    return (current + 32'd1 >= num) ? 32'd0 : current + 32'd1;
  endfunction

endpackage

// File: rtl/fpnew_hub_rr_arbiter.sv
// Combinational round-robin grant: first valid slice at or above the
// pointer, wrapping to the low indices when none is found there.
module fpnew_hub_rr_arbiter #(
  parameter int unsigned NumSlices = 2,
  parameter int unsigned IdxWidth  = 1
) (
  input  logic [NumSlices-1:0] i_valid,
  input  logic [IdxWidth-1:0]  i_rr,
  output logic [NumSlices-1:0] o_grant,
  output logic [IdxWidth-1:0]  o_idx,
  output logic                 o_any_valid
);

  logic w_found;

  always_comb begin
    // NOTE: every output gets a default before the search loops so no path
    // through the block leaves a value unassigned (which would infer a latch).
    w_found = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int unsigned i = 0; i < NumSlices; i++) begin
      if (!w_found && i >= 32'(i_rr) && i_valid[i]) begin
        o_grant[i] = 1'b1;
        o_idx      = IdxWidth'(i);
        w_found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NumSlices; i++) begin
      if (!w_found && i < 32'(i_rr) && i_valid[i]) begin
        o_grant[i] = 1'b1;
        o_idx      = IdxWidth'(i);
        w_found    = 1'b1;
      end
    end
    o_any_valid = w_found;
  end

endmodule

// File: rtl/fpnew_hub_opgroup_arbiter.sv
// Round-robin merge of per-format HUB opgroup slice outputs into one
// full-throughput registered output stage with valid/ready handshake.
module fpnew_hub_opgroup_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumSlices = 2,
  parameter int unsigned Width     = 32,
  parameter type         TagType   = logic,
  localparam int unsigned IdxWidth = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumSlices-1:0][Width-1:0]  slice_result_i,
  input  status_t [NumSlices-1:0]          slice_status_i,
  input  logic [NumSlices-1:0]             slice_ext_bit_i,
  input  TagType [NumSlices-1:0]           slice_tag_i,
  input  logic [NumSlices-1:0]             slice_valid_i,
  output logic [NumSlices-1:0]             slice_ready_o,
  input  logic [NumSlices-1:0]             slice_busy_i,
  input  logic                             flush_i,
  output logic [Width-1:0]                 result_o,
  output status_t                          status_o,
  output logic                             extension_bit_o,
  output TagType                           tag_o,
  output logic [IdxWidth-1:0]              fmt_idx_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             busy_o
);

  logic                 r_out_valid;
  logic [Width-1:0]     r_result;
  status_t              r_status;
  logic                 r_ext;
  TagType               r_tag;
  logic [IdxWidth-1:0]  r_idx;
  logic [IdxWidth-1:0]  r_rr;

  logic [NumSlices-1:0] w_grant;
  logic [IdxWidth-1:0]  w_idx;
  logic                 w_any_valid;
  logic                 w_reg_ready;
  logic                 w_accept;

  fpnew_hub_rr_arbiter #(
    .NumSlices (NumSlices),
    .IdxWidth  (IdxWidth)
  ) u_rr_arbiter (
    .i_valid     (slice_valid_i),
    .i_rr        (r_rr),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any_valid (w_any_valid)
  );

  // The output stage can take new data when empty or draining this cycle.
  assign w_reg_ready   = ~r_out_valid | out_ready_i;
  assign w_accept      = w_any_valid & w_reg_ready & ~flush_i;
  assign slice_ready_o = w_grant & {NumSlices{w_reg_ready & ~flush_i}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // NOTE: the data registers are reset too, so a reset mid-stall leaves
  // all-zero outputs rather than the stale held result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= '0;
      r_status <= '0;
      r_ext    <= 1'b0;
      r_tag    <= '0;
      r_idx    <= '0;
      r_rr     <= '0;
    end else if (w_accept) begin
      r_result <= slice_result_i[w_idx];
      r_status <= slice_status_i[w_idx];
      r_ext    <= slice_ext_bit_i[w_idx];
      r_tag    <= slice_tag_i[w_idx];
      r_idx    <= w_idx;
      r_rr     <= IdxWidth'(rr_next_idx(32'(w_idx), NumSlices));
    end
  end

  assign result_o        = r_result;
  assign status_o        = r_status;
  assign extension_bit_o = r_ext;
  assign tag_o           = r_tag;
  assign fmt_idx_o       = r_idx;
  assign out_valid_o     = r_out_valid;
  assign busy_o          = r_out_valid | (|slice_busy_i) | (|slice_valid_i);

endmodule

// File: tb/tb_fpnew_hub_opgroup_arbiter.sv
// Scoreboard bench for the HUB opgroup arbiter: a slice-level model predicts
// each accepted transaction; a negedge monitor compares what the DUT presents.
module tb_fpnew_hub_opgroup_arbiter;
  import fpnew_pkg::*;

  localparam int N = 2;
  localparam int W = 32;
  typedef logic [3:0] tag_t;

  typedef struct {
    logic [W-1:0] res;
    status_t      st;
    logic         ext;
    tag_t         tag;
    int           idx;
  } item_t;

  logic                    clk = 1'b0;
  logic                    rst_ni;
  logic [N-1:0][W-1:0]     slice_result;
  status_t [N-1:0]         slice_status;
  logic [N-1:0]            slice_ext;
  tag_t [N-1:0]            slice_tag;
  logic [N-1:0]            slice_valid;
  logic [N-1:0]            slice_ready;
  logic [N-1:0]            slice_busy;
  logic                    flush;
  logic [W-1:0]            result;
  status_t                 status;
  logic                    ext_bit;
  tag_t                    tag;
  logic                    fmt_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;

  fpnew_hub_opgroup_arbiter #(
    .NumSlices (N),
    .Width     (W),
    .TagType   (tag_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .slice_result_i  (slice_result),
    .slice_status_i  (slice_status),
    .slice_ext_bit_i (slice_ext),
    .slice_tag_i     (slice_tag),
    .slice_valid_i   (slice_valid),
    .slice_ready_o   (slice_ready),
    .slice_busy_i    (slice_busy),
    .flush_i         (flush),
    .result_o        (result),
    .status_o        (status),
    .extension_bit_o (ext_bit),
    .tag_o           (tag),
    .fmt_idx_o       (fmt_idx),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pending slice transactions, expected output occupancy, pointer.
  bit       pend [N];
  item_t    pdata [N];
  item_t    q [$];
  bit       m_valid = 1'b0;
  int       m_rr = 0;
  bit       mon_en = 1'b0;
  bit       cur_exp_valid = 1'b0;
  logic [N-1:0] cur_exp_ready = '0;
  bit       cur_exp_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input int s, input logic [W-1:0] res, input tag_t t);
    pend[s]       = 1'b1;
    pdata[s].res  = res;
    pdata[s].st   = status_t'($urandom_range(0, 31));
    pdata[s].ext  = 1'($urandom_range(0, 1));
    pdata[s].tag  = t;
    pdata[s].idx  = s;
  endtask

  // One clock cycle: drive slices from the pending table, predict the outcome
  // from the arbitration rules, then advance the model past the edge.
  task automatic step();
    int   win;
    bit   reg_ready;
    logic [N-1:0] exp_rdy;
    for (int s = 0; s < N; s++) begin
      slice_valid[s]  = pend[s];
      slice_result[s] = pdata[s].res;
      slice_status[s] = pdata[s].st;
      slice_ext[s]    = pdata[s].ext;
      slice_tag[s]    = pdata[s].tag;
    end
    reg_ready = !m_valid || out_ready;
    win = -1;
    for (int k = 0; k < N; k++) begin
      if (win < 0 && pend[(m_rr + k) % N]) win = (m_rr + k) % N;
    end
    exp_rdy = '0;
    if (win >= 0 && reg_ready && !flush) exp_rdy[win] = 1'b1;
    cur_exp_valid = m_valid;
    cur_exp_ready = exp_rdy;
    cur_exp_busy  = m_valid || (|slice_busy) || (|slice_valid);
    @(posedge clk);
    #1;
    if (flush) begin
      if (m_valid && !out_ready) void'(q.pop_back());
      m_valid = 1'b0;
    end else if (exp_rdy != '0) begin
      q.push_back(pdata[win]);
      pend[win] = 1'b0;
      m_rr      = (win + 1) % N;
      m_valid   = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && mon_en) begin
      check("out_valid", 64'(out_valid), 64'(cur_exp_valid));
      check("slice_ready", 64'(slice_ready), 64'(cur_exp_ready));
      check("busy", 64'(busy), 64'(cur_exp_busy));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty: got out_valid=1 expected no output (t=%0t)", $time);
        end else begin
          check("result", 64'(result), 64'(q[0].res));
          check("status", 64'(status), 64'(q[0].st));
          check("ext_bit", 64'(ext_bit), 64'(q[0].ext));
          check("tag", 64'(tag), 64'(q[0].tag));
          check("fmt_idx", 64'(fmt_idx), 64'(q[0].idx));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic model_reset();
    q.delete();
    for (int s = 0; s < N; s++) pend[s] = 1'b0;
    m_valid = 1'b0;
    m_rr    = 0;
    slice_valid = '0;
  endtask

  initial begin
    rst_ni = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    slice_busy = '0;
    slice_valid = '0;
    slice_result = '0;
    slice_status = '0;
    slice_ext = '0;
    slice_tag = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_fmt_idx", 64'(fmt_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Single transaction from slice 1; pointer then wraps to 0.
    out_ready = 1'b1;
    load(1, 32'h3F80_0000, 4'd5);
    step();
    step();

    // Contention: both slices refilled every cycle, drained every cycle.
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < N; s++) if (!pend[s]) load(s, $urandom, tag_t'($urandom_range(0, 15)));
      step();
    end
    for (int c = 0; c < 3; c++) step();

    // Backpressure: hold one result while slice 0 waits with 0x4000_0000.
    load(0, 32'h1234_5678, 4'd1);
    step();
    out_ready = 1'b0;
    load(0, 32'h4000_0000, 4'd2);
    for (int c = 0; c < 3; c++) step();
    out_ready = 1'b1;
    step();
    step();
    step();

    // Flush while holding a result, with slice 1 waiting.
    load(0, 32'hAAAA_0001, 4'd3);
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    load(1, 32'hBBBB_0002, 4'd4);
    step();
    flush = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    step();

    // Busy from a slice alone, then fully idle.
    slice_busy = 2'b10;
    step();
    slice_busy = 2'b00;
    step();

    // Async reset during a stall after slice 0 won (pointer at 1).
    load(0, 32'hCAFE_0000, 4'd6);
    out_ready = 1'b0;
    step();
    load(1, 32'hBEEF_0001, 4'd7);
    step();
    rst_ni = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_status", 64'(status), 64'd0);
    check("arst_ext", 64'(ext_bit), 64'd0);
    check("arst_tag", 64'(tag), 64'd0);
    check("arst_fmt_idx", 64'(fmt_idx), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    out_ready = 1'b1;
    load(1, 32'h0000_1111, 4'd8);
    load(0, 32'h0000_2222, 4'd9);
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic with backpressure, flushes and busy noise.
    for (int c = 0; c < 500; c++) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      slice_busy = N'($urandom_range(0, 3));
      for (int s = 0; s < N; s++)
        if (!pend[s] && $urandom_range(0, 1) == 1) load(s, $urandom, tag_t'($urandom_range(0, 15)));
      step();
    end

    // Drain everything and confirm nothing expected is left over.
    flush = 1'b0;
    out_ready = 1'b1;
    slice_busy = '0;
    for (int c = 0; c < 8; c++) step();
    @(negedge clk);
    #1;
    check("drain_queue", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
